// File: rtl/pd_fifo_buffer.sv
// Buffered ready/valid FIFO: first-word-fall-through output, registered in_ready,
// occupancy count, sticky peak-occupancy monitor and synchronous flush.
module pd_fifo_buffer #(
    parameter int DATA_WIDTH        = 8,
    parameter int DEPTH             = 4,
    parameter int ALMOST_FULL_LEVEL = DEPTH - 1,
    parameter int CW                = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CW-1:0]         count,
    output logic                  almost_full,
    output logic [CW-1:0]         peak_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count_next;
    logic                  push;
    logic                  pop;

    // Pointers wrap at DEPTH-1 so non-power-of-two depths work.
    function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    assign push      = in_valid & in_ready;
    assign out_valid = (count != '0);
    assign pop       = out_valid & out_ready;
    assign out_data  = mem[rd_ptr];

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + 1'b1;
        end else if (!push && pop) begin
            count_next = count - 1'b1;
        end
    end

    // Storage is not reset; a stale slot is never visible while out_valid=0.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            in_ready    <= 1'b0;
            almost_full <= 1'b0;
            peak_count  <= '0;
        end else if (flush) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            in_ready    <= 1'b1;
            almost_full <= 1'b0;
            peak_count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= bump(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= bump(rd_ptr);
            end
            count       <= count_next;
            in_ready    <= (count_next < CW'(DEPTH));
            almost_full <= (count_next >= CW'(ALMOST_FULL_LEVEL));
            if (count_next > peak_count) begin
                peak_count <= count_next;
            end
        end
    end

    a_no_overflow: assert property (
        @(posedge clk) disable iff (rst) push |-> (count < CW'(DEPTH)));

    a_no_underflow: assert property (
        @(posedge clk) disable iff (rst) pop |-> (count != '0));

    a_peak_bound: assert property (
        @(posedge clk) disable iff (rst) peak_count >= count);

    // A waiting producer must hold its word until it is taken.
    a_producer_hold: assert property (
        @(posedge clk) disable iff (rst)
        (in_valid && !push) |=> (in_valid && in_data == $past(in_data)));

endmodule
